mem_arbiter: RTL and testbench

//  Shares the single unified main-memory port between the instruction-fetch side (I) and the data side (D).
//  It sits between the fetch/memory pipeline stages and the memory.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, memory port and status.
// slave: the arbiter itself. master: requesters plus the memory model.
interface mem_arbiter_if;
  // Instruction-fetch side
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        i_err;
  // Data side
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        d_err;
  // Memory command / response
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  // Status
  logic        busy;
  logic [15:0] i_grant_cnt;
  logic [15:0] d_grant_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_en, mem_wr, mem_addr, mem_wdata, busy, i_grant_cnt, d_grant_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_en, mem_wr, mem_addr, mem_wdata, busy, i_grant_cnt, d_grant_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Unified memory-port arbiter between instruction fetch (I) and data (D).
// Serialises accesses to a fixed-latency memory, flags unaligned accesses,
// and keeps saturating per-side grant counters.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StErr} state_e;

  localparam logic [3:0] LatInit   = 4'(MEM_LAT);
  localparam logic [3:0] StarveTop = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic        side_q, side_d;      // 1 = data side owns the transaction
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic [15:0] i_cnt_q, i_cnt_d;
  logic [15:0] d_cnt_q, d_cnt_d;

  logic        grant_any;
  logic        grant_d;
  logic [15:0] grant_addr;

  // Arbitration: D wins ties unless I has waited through STARVE_MAX D grants.
  always_comb begin
    grant_any = bus_io.i_req | bus_io.d_req;
    if (bus_io.i_req && bus_io.d_req) begin
      grant_d = (starve_q != StarveTop);
    end else begin
      grant_d = bus_io.d_req;
    end
    grant_addr = grant_d ? bus_io.d_addr : bus_io.i_addr;
  end

  // Next-state logic for the transaction sequencer and its bookkeeping.
  always_comb begin
    state_d   = state_q;
    side_d    = side_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          side_d  = grant_d;
          wr_d    = grant_d & bus_io.d_wr;
          addr_d  = grant_addr;
          wdata_d = grant_d ? bus_io.d_wdata : 16'h0000;
          if (grant_d) begin
            // Only count D wins that actually kept a waiting fetch out.
            if (bus_io.i_req && (starve_q != StarveTop)) begin
              starve_d = starve_q + 4'd1;
            end
          end else begin
            starve_d = 4'd0;
          end
          state_d = grant_addr[0] ? StErr : StIssue;
        end
      end
      StIssue: begin
        lat_d = LatInit;
        if (side_q) begin
          d_cnt_d = (d_cnt_q == 16'hFFFF) ? d_cnt_q : d_cnt_q + 16'd1;
        end else begin
          i_cnt_d = (i_cnt_q == 16'hFFFF) ? i_cnt_q : i_cnt_q + 16'd1;
        end
        state_d = StWait;
      end
      StWait: begin
        // <= 1 so a corrupted zero count cannot wrap and hang the port.
        if (lat_q <= 4'd1) begin
          if (side_q) begin
            d_rdata_d = wr_q ? 16'h0000 : bus_io.mem_rdata;
          end else begin
            i_rdata_d = bus_io.mem_rdata;
          end
          state_d = StDone;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      side_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      lat_q     <= 4'd0;
      starve_q  <= 4'd0;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
      i_cnt_q   <= 16'h0000;
      d_cnt_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      side_q    <= side_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
    end
  end

  // Output decode: everything is gated by state so idle/non-owner outputs read 0.
  always_comb begin
    logic in_done;
    logic in_err;
    in_done = (state_q == StDone);
    in_err  = (state_q == StErr);

    bus_io.mem_en    = (state_q == StIssue);
    bus_io.mem_wr    = bus_io.mem_en & wr_q;
    bus_io.mem_addr  = bus_io.mem_en ? addr_q  : 16'h0000;
    bus_io.mem_wdata = bus_io.mem_en ? wdata_q : 16'h0000;

    bus_io.i_done  = (in_done | in_err) & ~side_q;
    bus_io.i_err   = in_err & ~side_q;
    bus_io.i_rdata = (in_done && !side_q) ? i_rdata_q : 16'h0000;

    bus_io.d_done  = (in_done | in_err) & side_q;
    bus_io.d_err   = in_err & side_q;
    bus_io.d_rdata = (in_done && side_q) ? d_rdata_q : 16'h0000;

    bus_io.busy        = (state_q != StIdle);
    bus_io.i_grant_cnt = i_cnt_q;
    bus_io.d_grant_cnt = d_cnt_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level schedule model predicts every
// output cycle by cycle; a memory responder supplies read data MEM_LAT late.
module tb_mem_arbiter;
  localparam int unsigned MemLat    = 2;
  localparam int unsigned StarveMax = 3;
  localparam int          MaxCyc    = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MEM_LAT   (MemLat),
    .STARVE_MAX(StarveMax)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Environment memory and reference memory (same initial image).
  logic [15:0] mem_arr [256];
  logic [15:0] ref_mem [256];

  // Memory responder: data valid only in the cycle MemLat after mem_en.
  logic [15:0] resp_data = 16'h0;
  int          resp_age  = -1;
  initial begin
    bus.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (resp_age >= 0) resp_age++;
      if (bus.mem_en) begin
        resp_data = mem_arr[bus.mem_addr[8:1]];
        if (bus.mem_wr) mem_arr[bus.mem_addr[8:1]] = bus.mem_wdata;
        resp_age = 0;
      end
      if (resp_age == int'(MemLat)) bus.mem_rdata = resp_data;
      else bus.mem_rdata = 16'($urandom);
    end
  end

  // Reference model state.
  int          m_starve = 0;
  logic [15:0] m_icnt   = 16'h0;
  logic [15:0] m_dcnt   = 16'h0;

  // Per-scenario request queues.
  int          in_n, dn_n;
  logic [15:0] iq_addr  [8];
  logic [15:0] dq_addr  [8];
  logic [15:0] dq_wdata [8];
  logic        dq_wr    [8];

  // Expected outputs per cycle of the current scenario.
  logic        e_busy [MaxCyc], e_en [MaxCyc], e_wr [MaxCyc];
  logic [15:0] e_addr [MaxCyc], e_wdata [MaxCyc];
  logic        e_idone [MaxCyc], e_ierr [MaxCyc], e_ddone [MaxCyc], e_derr [MaxCyc];
  logic [15:0] e_irdata [MaxCyc], e_drdata [MaxCyc], e_icnt [MaxCyc], e_dcnt [MaxCyc];
  logic        inc_i [MaxCyc], inc_d [MaxCyc];
  int          last_cyc;

  function automatic logic [102:0] obs();
    return {bus.busy, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
            bus.i_done, bus.i_err, bus.i_rdata, bus.d_done, bus.d_err, bus.d_rdata,
            bus.i_grant_cnt, bus.d_grant_cnt};
  endfunction

  function automatic logic [102:0] exp_at(int c);
    return {e_busy[c], e_en[c], e_wr[c], e_addr[c], e_wdata[c],
            e_idone[c], e_ierr[c], e_irdata[c], e_ddone[c], e_derr[c], e_drdata[c],
            e_icnt[c], e_dcnt[c]};
  endfunction

  task automatic chk(input string tag, input logic [102:0] got, input logic [102:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Build the cycle schedule: cycle 0 is the cycle requests are first raised.
  // Each side is pending whenever it has queued work; the next grant is taken
  // in the idle cycle right after a completion.
  task automatic plan();
    int t  = 0;
    int ih = 0;
    int dh = 0;
    for (int c = 0; c < MaxCyc; c++) begin
      e_busy[c] = 0; e_en[c] = 0; e_wr[c] = 0; e_addr[c] = 0; e_wdata[c] = 0;
      e_idone[c] = 0; e_ierr[c] = 0; e_irdata[c] = 0;
      e_ddone[c] = 0; e_derr[c] = 0; e_drdata[c] = 0;
      inc_i[c] = 0; inc_d[c] = 0;
    end
    while ((ih < in_n) || (dh < dn_n)) begin
      logic        take_d;
      logic [15:0] a;
      logic        w;
      logic [15:0] wd;
      int          done_c;
      if ((ih < in_n) && (dh < dn_n)) take_d = (m_starve != int'(StarveMax));
      else take_d = (dh < dn_n);
      if (take_d) begin
        if ((ih < in_n) && (m_starve < int'(StarveMax))) m_starve++;
        a = dq_addr[dh]; w = dq_wr[dh]; wd = dq_wdata[dh]; dh++;
      end else begin
        m_starve = 0;
        a = iq_addr[ih]; w = 1'b0; wd = 16'h0; ih++;
      end
      if (a[0]) begin
        done_c = t + 1;
        if (take_d) begin e_ddone[done_c] = 1; e_derr[done_c] = 1; end
        else begin e_idone[done_c] = 1; e_ierr[done_c] = 1; end
      end else begin
        done_c = t + 2 + int'(MemLat);
        e_en[t+1] = 1; e_wr[t+1] = w; e_addr[t+1] = a; e_wdata[t+1] = wd;
        if (take_d) begin
          inc_d[t+2] = 1; e_ddone[done_c] = 1;
          e_drdata[done_c] = w ? 16'h0 : ref_mem[a[8:1]];
        end else begin
          inc_i[t+2] = 1; e_idone[done_c] = 1;
          e_irdata[done_c] = ref_mem[a[8:1]];
        end
        if (w) ref_mem[a[8:1]] = wd;
      end
      for (int c = t + 1; c <= done_c; c++) e_busy[c] = 1;
      t = done_c + 1;
    end
    last_cyc = t;
    for (int c = 0; c < MaxCyc; c++) begin
      if (inc_i[c] && (m_icnt != 16'hFFFF)) m_icnt = m_icnt + 16'd1;
      if (inc_d[c] && (m_dcnt != 16'hFFFF)) m_dcnt = m_dcnt + 16'd1;
      e_icnt[c] = m_icnt;
      e_dcnt[c] = m_dcnt;
    end
  endtask

  // Plays the queued requests and compares every cycle against the schedule.
  task automatic run(input string tag);
    int ih = 0;
    int dh = 0;
    plan();
    if (in_n > 0) begin bus.i_req = 1'b1; bus.i_addr = iq_addr[0]; end
    if (dn_n > 0) begin
      bus.d_req = 1'b1; bus.d_addr = dq_addr[0];
      bus.d_wr = dq_wr[0]; bus.d_wdata = dq_wdata[0];
    end
    for (int c = 1; c <= last_cyc; c++) begin
      @(negedge clk);
      chk($sformatf("%s cyc%0d", tag, c), obs(), exp_at(c));
      if (bus.i_done) begin
        bus.i_req = 1'b0; ih++;
      end else if (!bus.i_req && (ih < in_n)) begin
        bus.i_req = 1'b1; bus.i_addr = iq_addr[ih];
      end
      if (bus.d_done) begin
        bus.d_req = 1'b0; dh++;
      end else if (!bus.d_req && (dh < dn_n)) begin
        bus.d_req = 1'b1; bus.d_addr = dq_addr[dh];
        bus.d_wr = dq_wr[dh]; bus.d_wdata = dq_wdata[dh];
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0;
    for (int k = 0; k < 256; k++) begin
      mem_arr[k] = 16'(k * 257) ^ 16'h5A3C;
      ref_mem[k] = 16'(k * 257) ^ 16'h5A3C;
    end
    mem_arr[8] = 16'hBEEF;
    ref_mem[8] = 16'hBEEF;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_outputs", obs(), '0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_release", obs(), '0);

    // Lone load from 0x0010 returns BEEF.
    in_n = 0; dn_n = 1;
    dq_addr[0] = 16'h0010; dq_wr[0] = 0; dq_wdata[0] = 16'h0;
    run("lone_load");
    chk("lone_load_cnt", 103'(bus.d_grant_cnt), 103'd1);

    // Simultaneous first requests: D first, then I.
    in_n = 1; dn_n = 1;
    iq_addr[0] = 16'h0020;
    dq_addr[0] = 16'h0030; dq_wr[0] = 0; dq_wdata[0] = 16'h1111;
    run("simul");

    // Starvation guard: D keeps re-requesting while I waits.
    in_n = 1; dn_n = 4;
    iq_addr[0] = 16'h0100;
    for (int k = 0; k < 4; k++) begin
      dq_addr[k] = 16'(16'h0200 + 2 * k); dq_wr[k] = k[0]; dq_wdata[k] = 16'(16'hA000 + k);
    end
    run("starve");

    // Unaligned store and unaligned fetch.
    in_n = 0; dn_n = 1;
    dq_addr[0] = 16'h0003; dq_wr[0] = 1; dq_wdata[0] = 16'h7777;
    run("unaligned_store");
    in_n = 1; dn_n = 0;
    iq_addr[0] = 16'h0005;
    run("unaligned_fetch");

    // Store then load the same word.
    in_n = 0; dn_n = 2;
    dq_addr[0] = 16'h0044; dq_wr[0] = 1; dq_wdata[0] = 16'h1234;
    dq_addr[1] = 16'h0044; dq_wr[1] = 0; dq_wdata[1] = 16'h0;
    run("store_load");

    // Randomized mixes.
    for (int r = 0; r < 10; r++) begin
      in_n = $urandom_range(0, 3);
      dn_n = $urandom_range(0, 4);
      if ((in_n == 0) && (dn_n == 0)) dn_n = 1;
      for (int k = 0; k < 8; k++) begin
        iq_addr[k] = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 7) == 0) iq_addr[k][0] = 1'b1;
        dq_addr[k] = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 7) == 0) dq_addr[k][0] = 1'b1;
        dq_wr[k]    = 1'($urandom);
        dq_wdata[k] = 16'($urandom);
      end
      run($sformatf("rand%0d", r));
    end

    // Reset asserted while a fetch is waiting on memory.
    bus.i_req = 1'b1; bus.i_addr = 16'h0040;
    @(negedge clk);
    chk("rst_issue_en", 103'(bus.mem_en), 103'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_async_clear", obs(), '0);
    bus.i_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_hold_quiet", obs(), '0);
    end
    m_starve = 0; m_icnt = 16'h0; m_dcnt = 16'h0;
    rst = 1'b1;
    in_n = 1; dn_n = 0;
    iq_addr[0] = 16'h0040;
    run("after_rst");

    // Saturation of the fetch grant counter.
    force dut.i_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.i_cnt_q;
    m_icnt = 16'hFFFE;
    in_n = 3; dn_n = 0;
    iq_addr[0] = 16'h0060; iq_addr[1] = 16'h0062; iq_addr[2] = 16'h0064;
    run("saturate");
    @(negedge clk);
    chk("sat_hold", 103'(bus.i_grant_cnt), 103'h0FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
